controle_multiciclo: RTL

//  Multicycle control FSM directly upstream of the register file. Its 4-bit state

---
 rtl/controle_multiciclo.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/controle_multiciclo.sv
// Multicycle control FSM for an RV32I subset (R, I-ALU, load, store, branch).
// It sequences PC, IR, memory and ALU muxes and counts retired instructions.
//   state    | meaning
//   FETCH    | read instruction, PC+4; waits on mem_ready
//   DECODE   | PC+imm<<1 precomputed; dispatch on opcode
//   MEMADR   | rs1+imm effective address
//   MEMREAD  | load access; waits on mem_ready
//   MEMWRITE | store access; waits on mem_ready, retires
//   EXECUTE  | ALU op on rs1 and rs2/imm
//   ALUWB    | write ALU result, retires
//   MEMWB    | write load data, retires
//   BRANCH   | compare, conditional PC update, retires
//   HALT     | parked until reset
module controle_multiciclo #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic [3:0]       estado,
  output logic             regiwrite,
  output logic             memtoreg,
  output logic             irwrite,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic             memread,
  output logic             memwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'b0000,
    S_DECODE   = 4'b0001,
    S_MEMADR   = 4'b0010,
    S_MEMREAD  = 4'b0011,
    S_MEMWRITE = 4'b0100,
    S_EXECUTE  = 4'b0101,
    S_ALUWB    = 4'b0110,
    S_MEMWB    = 4'b0111,
    S_BRANCH   = 4'b1000,
    S_HALT     = 4'b1001
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_HALT  = 7'b0000000;

  state_t             state_q, state_d;
  logic               illegal_q, illegal_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               retire;

  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    retire    = 1'b0;
    case (state_q)
      S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_R, OP_I:        state_d = S_EXECUTE;
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_BR:             state_d = S_BRANCH;
          OP_HALT:           state_d = S_HALT;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR:  state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: begin
        state_d = mem_ready ? S_FETCH : S_MEMWRITE;
        retire  = mem_ready;
      end
      S_EXECUTE: state_d = S_ALUWB;
      S_ALUWB, S_MEMWB, S_BRANCH: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase
    retired_d = retire ? retired_q + {{(CNT_W-1){1'b0}}, 1'b1} : retired_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // Moore decode of the state; only irwrite/pcwrite look at mem_ready
  always_comb begin
    regiwrite   = 1'b0;
    memtoreg    = 1'b0;
    irwrite     = 1'b0;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = 2'b00;
    aluop       = 2'b00;
    halted      = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = 2'b01;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE:  alusrcb = 2'b11;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMREAD:  memread  = 1'b1;
      S_MEMWRITE: memwrite = 1'b1;
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
        alusrcb = (opcode == OP_R) ? 2'b00 : 2'b10;
      end
      S_ALUWB:   regiwrite = 1'b1;
      S_MEMWB: begin
        regiwrite = 1'b1;
        memtoreg  = 1'b1;
      end
      S_BRANCH: begin
        alusrca     = 1'b1;
        aluop       = 2'b01;
        pcwritecond = 1'b1;
      end
      S_HALT:    halted = 1'b1;
      default: ;
    endcase
  end

  assign estado  = state_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule
